// File: rtl/ysyx_25020047_lsu_resp.sv
// ysyx_25020047_lsu_resp: load/store responder with an internal word SRAM, programmable latency and an error flag
module ysyx_25020047_lsu_resp #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state, state_n;
    logic          write_q;
    logic [1:0]    size_q;
    logic [31:0]   addr_q, wdata_q, cnt;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   off, word, lane_byte;
    logic [AW-1:0] idx;
    logic [4:0]    sh;
    logic          legal, commit;

    // Decode the latched request: range/alignment check, word index, byte lane and commit point
    always_comb begin
        off       = addr_q - BASE_ADDR;
        idx       = off[AW+1:2];
        legal     = (off < 32'(4 * DEPTH_WORDS)) &&
                    (size_q == 2'b00 || (size_q == 2'b10 && addr_q[1:0] == 2'b00));
        word      = mem[idx];
        sh        = {addr_q[1:0], 3'b000};
        lane_byte = (word >> sh) & 32'h0000_00ff;
        commit    = (state == S_WAIT) && (cnt == 32'd0);
    end

    // State register; reset returns to IDLE immediately, dropping any uncommitted access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next state: accept in IDLE, wait out the latency, hold the response until taken
    always_comb begin
        state_n = state;
        if (state == S_IDLE && req_valid)  state_n = S_WAIT;
        if (commit)                        state_n = S_RESP;
        if (state == S_RESP && resp_ready) state_n = S_IDLE;
    end

    // Handshake outputs decoded from the state
    always_comb begin
        req_ready  = (state == S_IDLE);
        resp_valid = (state == S_RESP);
    end

    // Request latch, latency counter and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            cnt        <= 32'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else if (state == S_IDLE && req_valid) begin
            write_q <= req_write;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= 32'(LATENCY - 1);
        end else if (commit) begin
            resp_err   <= !legal;
            resp_rdata <= (!legal || write_q) ? 32'd0 : (size_q == 2'b10 ? word : lane_byte);
        end else if (state == S_WAIT) begin
            cnt <= cnt - 32'd1;
        end
    end

    // SRAM write port; contents survive reset and a store lands only on the commit edge
    always_ff @(posedge clk) begin
        if (commit && legal && write_q) begin
            if (size_q == 2'b10) mem[idx] <= wdata_q;
            else                 mem[idx][sh +: 8] <= wdata_q[7:0];
        end
    end
endmodule
